// File: rtl/rv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// rv_hazard_ctrl
// Hazard controller for the 5-stage RV32I pipeline. Keeps a shadow copy of
// the register usage of the instructions in EX, MEM and WB. From that copy
// and the ID-stage inputs it derives the EX operand forward selects and the
// stall/flush controls.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   rs1D/rs2D/rdD         : register indices of the ID instruction
//   uses_rs1D/uses_rs2D   : ID instruction reads rs1 / rs2
//   reg_writeD/mem_readD  : ID instruction writes rd / is a load
//   validD                : ID holds a real instruction
//   branch_takenE         : EX resolved a taken branch/jump
//   dmem_busy             : data memory not ready, whole pipe holds
//   stallF..stallW        : hold PC and the pipeline registers
//   flushD/flushE         : insert a bubble into IF/ID and ID/EX
//   forward_rs1E/rs2E     : 2'b11 MEM result, 2'b10 WB data, 2'b00 normal
//   hz_state              : previous cycle's winning condition (debug only)
//   stall_cnt             : free-running count of cycles with stallF=1
//
// Priority of events: rst > dmem_busy > branch_takenE > load-use > normal.
// Handshake note: there is no valid/ready pair here. A stall means the
// upstream stage holds its outputs, and a flush means the downstream register
// loads a bubble. Both take effect on the next rising edge.
// ---------------------------------------------------------------------------
module rv_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdD,
    input  logic                  uses_rs1D,
    input  logic                  uses_rs2D,
    input  logic                  reg_writeD,
    input  logic                  mem_readD,
    input  logic                  validD,
    input  logic                  branch_takenE,
    input  logic                  dmem_busy,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  stallW,
    output logic                  flushD,
    output logic                  flushE,
    output logic [1:0]            forward_rs1E,
    output logic [1:0]            forward_rs2E,
    output logic [1:0]            hz_state,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_SQUASH   = 2'd3;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // EX shadow stage
    logic                  r_validE, r_uses_rs1E, r_uses_rs2E, r_reg_writeE, r_mem_readE;
    logic [REG_ADDR_W-1:0] r_rs1E, r_rs2E, r_rdE;
    // MEM and WB shadow stages
    logic                  r_validM, r_reg_writeM, r_validW, r_reg_writeW;
    logic [REG_ADDR_W-1:0] r_rdM, r_rdW;

    logic [1:0]            r_hz_state;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_lu, w_mem_wait, w_squash, w_lu_stall;
    logic w_m_hit1, w_w_hit1, w_m_hit2, w_w_hit2;
    logic w_m_wr, w_w_wr;

    // A producer can only forward if it is real, writes a register, and that
    // register is not x0.
    assign w_m_wr = r_validM & r_reg_writeM & (r_rdM != X0);
    assign w_w_wr = r_validW & r_reg_writeW & (r_rdW != X0);

    assign w_m_hit1 = w_m_wr & (r_rdM == r_rs1E) & r_uses_rs1E;
    assign w_w_hit1 = w_w_wr & (r_rdW == r_rs1E) & r_uses_rs1E;
    assign w_m_hit2 = w_m_wr & (r_rdM == r_rs2E) & r_uses_rs2E;
    assign w_w_hit2 = w_w_wr & (r_rdW == r_rs2E) & r_uses_rs2E;

    assign w_lu = r_validE & r_mem_readE & r_reg_writeE & (r_rdE != X0) & validD &
                  ((uses_rs1D & (rs1D == r_rdE)) | (uses_rs2D & (rs2D == r_rdE)));

    // Mutually exclusive winners of the priority chain. A taken branch
    // discards the ID instruction, so it also removes any load-use hazard.
    assign w_mem_wait = ~rst & dmem_busy;
    assign w_squash   = ~rst & ~dmem_busy & branch_takenE;
    assign w_lu_stall = ~rst & ~dmem_busy & ~branch_takenE & w_lu;

    assign stallF = w_mem_wait | w_lu_stall;
    assign stallD = w_mem_wait | w_lu_stall;
    assign stallE = w_mem_wait;
    assign stallM = w_mem_wait;
    assign stallW = w_mem_wait;
    assign flushD = w_squash;
    assign flushE = w_squash | w_lu_stall;

    // The MEM result is the younger one, so it takes precedence over WB.
    // While dmem_busy is high the shadow regs are frozen, which keeps these
    // selects stable without any extra holding logic.
    always_comb begin
        forward_rs1E = 2'b00;
        forward_rs2E = 2'b00;
        if (!rst) begin
            if (w_m_hit1)      forward_rs1E = 2'b11;
            else if (w_w_hit1) forward_rs1E = 2'b10;
            if (w_m_hit2)      forward_rs2E = 2'b11;
            else if (w_w_hit2) forward_rs2E = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_validE     <= 1'b0;
            r_rs1E       <= '0;
            r_rs2E       <= '0;
            r_rdE        <= '0;
            r_uses_rs1E  <= 1'b0;
            r_uses_rs2E  <= 1'b0;
            r_reg_writeE <= 1'b0;
            r_mem_readE  <= 1'b0;
            r_validM     <= 1'b0;
            r_rdM        <= '0;
            r_reg_writeM <= 1'b0;
            r_validW     <= 1'b0;
            r_rdW        <= '0;
            r_reg_writeW <= 1'b0;
            r_hz_state   <= ST_RUN;
            r_stall_cnt  <= '0;
        end else begin
            if (stallF)
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

            if (w_mem_wait)      r_hz_state <= ST_MEM_WAIT;
            else if (w_squash)   r_hz_state <= ST_SQUASH;
            else if (w_lu_stall) r_hz_state <= ST_LU_STALL;
            else                 r_hz_state <= ST_RUN;

            if (!dmem_busy) begin
                r_validW     <= r_validM;
                r_rdW        <= r_rdM;
                r_reg_writeW <= r_reg_writeM;
                r_validM     <= r_validE;
                r_rdM        <= r_rdE;
                r_reg_writeM <= r_reg_writeE;
                // A flushed EX keeps the ID fields but is marked as a bubble.
                r_validE     <= validD & ~flushE;
                r_rs1E       <= rs1D;
                r_rs2E       <= rs2D;
                r_rdE        <= rdD;
                r_uses_rs1E  <= uses_rs1D;
                r_uses_rs2E  <= uses_rs2D;
                r_reg_writeE <= reg_writeD;
                r_mem_readE  <= mem_readD;
            end
        end
    end

    assign hz_state  = r_hz_state;
    assign stall_cnt = r_stall_cnt;

endmodule
